ltf_safety_monitor: RTL and testbench

- Downstream of top_level; consumes the four 3-bit lamp vectors (ltfs) every clock.
- Checks for illegal lamp patterns, conflicting greens, illegal lamp transitions and short yellow phases.
- Forwards the lamps to the physical drivers with one register stage.
- On the first fault it latches a fault record and overrides all lamps with synchronised flashing yellow until an operator clear.

---
 rtl/ltf_pkg.sv | 24 ++
 rtl/ltf_safety_monitor_if.sv | 24 ++
 rtl/ltf_lane_checker.sv | 51 +++++
 rtl/ltf_safety_monitor.sv | 152 +++++++++++++++
 tb/tb_ltf_safety_monitor.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ltf_pkg.sv
// Shared lamp encodings and fault codes for the traffic-light safety monitor.
package ltf_pkg;

  // Bit [0] is red, [1] is yellow, [2] is green.
  typedef logic [0:2] ltf_t;

  localparam ltf_t LTF_OFF    = 3'b000;
  localparam ltf_t LTF_RED    = 3'b100;
  localparam ltf_t LTF_YELLOW = 3'b010;
  localparam ltf_t LTF_GREEN  = 3'b001;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_CONFLICT     = 3'd1,
    FC_PATTERN      = 3'd2,
    FC_TRANSITION   = 3'd3,
    FC_SHORT_YELLOW = 3'd4
  } fault_code_e;

  function automatic logic is_legal_pattern(input ltf_t v);
    return (v == LTF_OFF) || (v == LTF_RED) || (v == LTF_YELLOW) || (v == LTF_GREEN);
  endfunction

endpackage

// File: rtl/ltf_safety_monitor_if.sv
// Lamp input/output bundle between top_level, the safety monitor and the lamp drivers.
interface ltf_safety_monitor_if #(
  parameter int N_SEM = 4
);
  import ltf_pkg::*;

  ltf_t [N_SEM-1:0] ltfs;
  logic             clear_fault;
  ltf_t [N_SEM-1:0] safe_ltfs;
  logic             fault;
  fault_code_e      fault_code;
  logic [1:0]       fault_sem;

  modport master (
    output ltfs, clear_fault,
    input  safe_ltfs, fault, fault_code, fault_sem
  );

  modport slave (
    input  ltfs, clear_fault,
    output safe_ltfs, fault, fault_code, fault_sem
  );

endinterface

// File: rtl/ltf_lane_checker.sv
// Per-semaphore checker: tracks the previous sample and yellow duration, flags lane-local faults.
module ltf_lane_checker
  import ltf_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic clk,
  input  logic rst,
  input  ltf_t cur,
  output logic bad_pattern,
  output logic bad_transition,
  output logic short_yellow,
  output logic green
);

  localparam int             YW   = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
  localparam logic [YW-1:0]  YSAT = YW'(MIN_YELLOW);

  ltf_t          prev_q, prev_d;
  logic [YW-1:0] ycnt_q, ycnt_d;
  logic          legal_move;

  always_comb begin
    bad_pattern = !is_legal_pattern(cur);
    legal_move  = (cur == prev_q) ||
                  ({prev_q, cur} inside {6'b000_100, 6'b000_010, 6'b100_001, 6'b001_010,
                                         6'b010_100, 6'b010_000, 6'b100_000});
    // A garbled sample carries no meaningful move, so only the pattern fault is reported.
    bad_transition = !bad_pattern && !legal_move;
    short_yellow   = !bad_pattern && (prev_q == LTF_YELLOW) && (cur == LTF_RED) &&
                     (ycnt_q < YSAT);
    green          = cur[2];

    prev_d = cur;
    ycnt_d = '0;
    if (cur == LTF_YELLOW) begin
      ycnt_d = (ycnt_q == YSAT) ? ycnt_q : ycnt_q + YW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= LTF_OFF;
      ycnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      ycnt_q <= ycnt_d;
    end
  end

endmodule

// File: rtl/ltf_safety_monitor.sv
// Lamp safety monitor: registered pass-through to the drivers, with a latched fault record and flashing-yellow override.
module ltf_safety_monitor
  import ltf_pkg::*;
#(
  parameter int          N_SEM         = 4,
  parameter int          MIN_YELLOW    = 3,
  parameter int          BLINK_HALF    = 2,
  parameter logic [15:0] CONFLICT_MASK = 16'h5A5A
) (
  input  logic                 clk,
  input  logic                 rst,
  ltf_safety_monitor_if.slave  mon
);

  localparam int            BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic {ST_MONITOR = 1'b0, ST_FAULT = 1'b1} state_e;

  logic [N_SEM-1:0] bad_pat, bad_tr, short_y, green;

  for (genvar g = 0; g < N_SEM; g++) begin : g_lane
    ltf_lane_checker #(.MIN_YELLOW(MIN_YELLOW)) u_lane (
      .clk           (clk),
      .rst           (rst),
      .cur           (mon.ltfs[g]),
      .bad_pattern   (bad_pat[g]),
      .bad_transition(bad_tr[g]),
      .short_yellow  (short_y[g]),
      .green         (green[g])
    );
  end

  logic        any_conf, any_pat, any_tr, any_sy, all_red, clear_ok, det;
  logic [1:0]  conf_sem, pat_sem, tr_sem, sy_sem, det_sem;
  fault_code_e det_code;

  // Each class is scanned from the top index down so the lowest offending index is left standing.
  always_comb begin
    any_conf = 1'b0; conf_sem = '0;
    any_pat  = 1'b0; pat_sem  = '0;
    any_tr   = 1'b0; tr_sem   = '0;
    any_sy   = 1'b0; sy_sem   = '0;
    all_red  = 1'b1;
    for (int i = N_SEM - 1; i >= 0; i--) begin
      for (int j = 0; j < N_SEM; j++) begin
        if ((j > i) && green[i] && green[j] && CONFLICT_MASK[4*i+j]) begin
          any_conf = 1'b1;
          conf_sem = 2'(i);
        end
      end
      if (bad_pat[i]) begin any_pat = 1'b1; pat_sem = 2'(i); end
      if (bad_tr[i])  begin any_tr  = 1'b1; tr_sem  = 2'(i); end
      if (short_y[i]) begin any_sy  = 1'b1; sy_sem  = 2'(i); end
      if (mon.ltfs[i] != LTF_RED) all_red = 1'b0;
    end

    det_code = FC_NONE;
    det_sem  = '0;
    if (any_conf)     begin det_code = FC_CONFLICT;     det_sem = conf_sem; end
    else if (any_pat) begin det_code = FC_PATTERN;      det_sem = pat_sem;  end
    else if (any_tr)  begin det_code = FC_TRANSITION;   det_sem = tr_sem;   end
    else if (any_sy)  begin det_code = FC_SHORT_YELLOW; det_sem = sy_sem;   end
    det      = (det_code != FC_NONE);
    clear_ok = mon.clear_fault && all_red;
  end

  state_e           state_q, state_d;
  logic             fault_q, fault_d;
  fault_code_e      code_q, code_d;
  logic [1:0]       sem_q, sem_d;
  logic             phase_q, phase_d, phase_adv;
  logic [BW-1:0]    bcnt_q, bcnt_d, bcnt_adv;
  ltf_t [N_SEM-1:0] safe_q, safe_d, all_yellow;

  always_comb begin
    for (int i = 0; i < N_SEM; i++) all_yellow[i] = LTF_YELLOW;

    phase_adv = phase_q;
    bcnt_adv  = bcnt_q + BW'(1);
    if (bcnt_q == BLINK_LAST) begin
      bcnt_adv  = '0;
      phase_adv = !phase_q;
    end

    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    sem_d   = sem_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    safe_d  = mon.ltfs;

    unique case (state_q)
      ST_MONITOR: begin
        if (det) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = det_code;
          sem_d   = det_sem;
          phase_d = 1'b1;
          bcnt_d  = '0;
          safe_d  = all_yellow;
        end
      end
      ST_FAULT: begin
        phase_d = phase_adv;
        bcnt_d  = bcnt_adv;
        safe_d  = phase_adv ? all_yellow : '0;
        // A fresh fault on a clear edge keeps the override and takes over the record.
        if (clear_ok && det) begin
          code_d = det_code;
          sem_d  = det_sem;
        end else if (clear_ok) begin
          state_d = ST_MONITOR;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          sem_d   = '0;
          phase_d = 1'b0;
          bcnt_d  = '0;
        end
      end
      default: state_d = ST_MONITOR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_MONITOR;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      sem_q   <= '0;
      phase_q <= 1'b0;
      bcnt_q  <= '0;
      safe_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      sem_q   <= sem_d;
      phase_q <= phase_d;
      bcnt_q  <= bcnt_d;
      safe_q  <= safe_d;
    end
  end

  assign mon.safe_ltfs  = safe_q;
  assign mon.fault      = fault_q;
  assign mon.fault_code = code_q;
  assign mon.fault_sem  = sem_q;

endmodule

// File: tb/tb_ltf_safety_monitor.sv
// Scoreboard bench for ltf_safety_monitor: directed scenarios plus random lamp traffic against a rule-level model.
module tb_ltf_safety_monitor;
  import ltf_pkg::*;

  localparam int          N_SEM         = 4;
  localparam int          MIN_YELLOW    = 3;
  localparam int          BLINK_HALF    = 2;
  localparam logic [15:0] CONFLICT_MASK = 16'h5A5A;

  typedef ltf_t [N_SEM-1:0] lanes_t;
  typedef struct {
    lanes_t     safe;
    logic       fault;
    logic [2:0] code;
    logic [1:0] sem;
  } exp_t;

  localparam ltf_t O = LTF_OFF, R = LTF_RED, Y = LTF_YELLOW, G = LTF_GREEN;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t q[$];

  ltf_safety_monitor_if #(.N_SEM(N_SEM)) ifc ();

  ltf_safety_monitor #(
    .N_SEM(N_SEM), .MIN_YELLOW(MIN_YELLOW), .BLINK_HALF(BLINK_HALF), .CONFLICT_MASK(CONFLICT_MASK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mon(ifc.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  ltf_t m_prev[N_SEM];
  int   m_ycnt[N_SEM];
  bit   m_fault;
  int   m_code, m_sem, m_age;

  function automatic bit one_lamp(input ltf_t v);
    return $countones(v) <= 1;
  endfunction

  function automatic bit move_ok(input ltf_t a, input ltf_t b);
    if (a == b) return 1'b1;
    case (a)
      O:       return (b == R) || (b == Y);
      R:       return (b == G) || (b == O);
      G:       return (b == Y);
      Y:       return (b == R) || (b == O);
      default: return 1'b0;
    endcase
  endfunction

  function automatic lanes_t fill(input ltf_t v);
    lanes_t r;
    for (int i = 0; i < N_SEM; i++) r[i] = v;
    return r;
  endfunction

  function automatic lanes_t L(input ltf_t a, input ltf_t b, input ltf_t c, input ltf_t d);
    lanes_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_SEM; i++) begin m_prev[i] = O; m_ycnt[i] = 0; end
    m_fault = 0; m_code = 0; m_sem = 0; m_age = 0;
  endtask

  task automatic model_step(input lanes_t cur, input bit clr, output exp_t e);
    int code = 0, sem = 0;
    bit all_red = 1;
    for (int i = 0; i < N_SEM; i++)
      for (int j = i + 1; j < N_SEM; j++)
        if (code == 0 && cur[i][2] && cur[j][2] && CONFLICT_MASK[4*i+j]) begin code = 1; sem = i; end
    for (int i = 0; i < N_SEM; i++)
      if (code == 0 && !one_lamp(cur[i])) begin code = 2; sem = i; end
    for (int i = 0; i < N_SEM; i++)
      if (code == 0 && one_lamp(cur[i]) && !move_ok(m_prev[i], cur[i])) begin code = 3; sem = i; end
    for (int i = 0; i < N_SEM; i++)
      if (code == 0 && one_lamp(cur[i]) && m_prev[i] == Y && cur[i] == R && m_ycnt[i] < MIN_YELLOW) begin
        code = 4; sem = i;
      end
    for (int i = 0; i < N_SEM; i++) if (cur[i] != R) all_red = 0;

    if (!m_fault) begin
      if (code != 0) begin
        m_fault = 1; m_age = 0; m_code = code; m_sem = sem;
        e.safe = fill(Y);
      end else begin
        e.safe = cur;
      end
    end else begin
      m_age++;
      e.safe = (((m_age / BLINK_HALF) % 2) == 0) ? fill(Y) : fill(O);
      if (clr && all_red) begin
        if (code != 0) begin m_code = code; m_sem = sem; end
        else begin m_fault = 0; m_code = 0; m_sem = 0; end
      end
    end
    e.fault = m_fault;
    e.code  = 3'(m_code);
    e.sem   = 2'(m_sem);

    for (int i = 0; i < N_SEM; i++) begin
      m_ycnt[i] = (cur[i] == Y) ? ((m_ycnt[i] < MIN_YELLOW) ? m_ycnt[i] + 1 : MIN_YELLOW) : 0;
      m_prev[i] = cur[i];
    end
  endtask

  task automatic apply(input lanes_t v, input bit clr);
    exp_t e;
    ifc.ltfs        = v;
    ifc.clear_fault = clr;
    model_step(v, clr, e);
    q.push_back(e);
  endtask

  task automatic step(input lanes_t v, input bit clr = 1'b0);
    @(negedge clk);
    apply(v, clr);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (ifc.safe_ltfs !== '0 || ifc.fault !== 1'b0 || ifc.fault_code !== FC_NONE || ifc.fault_sem !== 2'd0) begin
      errors++;
      $display("FAIL %s: safe=%h fault=%b code=%0d sem=%0d, required all zero",
               name, ifc.safe_ltfs, ifc.fault, ifc.fault_code, ifc.fault_sem);
    end
  endtask

  function automatic ltf_t succ(input ltf_t a);
    int r = $urandom_range(0, 2);
    case (a)
      O:       return (r == 0) ? O : (r == 1) ? R : Y;
      R:       return (r == 0) ? R : (r == 1) ? G : O;
      G:       return (r == 0) ? Y : G;
      Y:       return (r == 0) ? Y : (r == 1) ? R : O;
      default: return R;
    endcase
  endfunction

  // Monitor: one expected record per clocked sample
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (ifc.safe_ltfs !== e.safe || ifc.fault !== e.fault ||
            ifc.fault_code !== e.code || ifc.fault_sem !== e.sem) begin
          errors++;
          $display("FAIL out@%0t: got safe=%h fault=%b code=%0d sem=%0d, want safe=%h fault=%b code=%0d sem=%0d",
                   $time, ifc.safe_ltfs, ifc.fault, ifc.fault_code, ifc.fault_sem,
                   e.safe, e.fault, e.code, e.sem);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    lanes_t v;
    model_reset();
    ifc.ltfs        = '0;
    ifc.clear_fault = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(L(O, R, R, R), 1'b0);

    // Legal lane-0 cycle with exactly three yellow cycles
    step(L(R, R, R, R)); step(L(G, R, R, R));
    step(L(Y, R, R, R)); step(L(Y, R, R, R)); step(L(Y, R, R, R));
    step(L(R, R, R, R));

    // Conflicting greens, then blink, clear refused while lane 0 is green
    step(L(G, G, R, R));
    repeat (4) step(L(G, G, R, R));
    step(L(G, G, R, R), 1'b1);
    repeat (3) step(L(Y, Y, R, R));
    step(L(R, R, R, R));
    step(L(R, R, R, R), 1'b1);
    step(L(R, R, R, R));
    step(L(R, R, R, R));

    // Bad pattern, later illegal transition keeps the first record
    step(L(R, R, 3'b110, R));
    step(L(R, R, R, G));
    step(L(R, R, R, R));
    step(L(R, R, R, R), 1'b1);
    step(L(R, R, R, R));

    // Fault arriving on a valid clear edge replaces the record
    step(L(R, R, R, G));
    step(L(R, R, R, 3'b011));
    step(L(R, R, R, G));
    step(L(R, R, R, R), 1'b1);
    step(L(R, R, R, R), 1'b1);
    step(L(R, R, R, R));

    // Short yellow on lane 1, then an exactly-minimum yellow
    step(L(R, G, R, R));
    step(L(R, Y, R, R)); step(L(R, Y, R, R));
    step(L(R, R, R, R));
    step(L(R, R, R, R), 1'b1);
    step(L(R, G, R, R));
    repeat (3) step(L(R, Y, R, R));
    step(L(R, R, R, R));
    step(L(R, R, R, R), 1'b1);

    // Asynchronous reset in the middle of the blink
    step(L(R, R, G, G));
    repeat (3) step(L(R, R, G, G));
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check_zero("async_reset_mid_blink");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(L(R, R, R, R), 1'b0);
    step(L(R, R, R, R));

    // Random traffic with periodic all-red clear windows
    v = L(R, R, R, R);
    for (int k = 0; k < 400; k++) begin
      bit clr;
      if ((k % 16) >= 12) begin
        v   = fill(R);
        clr = 1'b1;
      end else begin
        for (int i = 0; i < N_SEM; i++)
          v[i] = ($urandom_range(0, 99) < 6) ? ltf_t'($urandom_range(0, 7)) : succ(v[i]);
        clr = ($urandom_range(0, 3) == 0);
      end
      step(v, clr);
    end

    for (int n = 0; n < 10 && q.size() > 0; n++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
